// File: rtl/alu_pkg.sv
// Shared alu definitions: control codes, flag bit positions and the legality check.
package alu_pkg;

  localparam int unsigned CTRL_W = 4;
  localparam int unsigned FLAG_W = 5;

  localparam int unsigned FLAG_EQ   = 0;
  localparam int unsigned FLAG_GTEU = 1;
  localparam int unsigned FLAG_LTU  = 2;
  localparam int unsigned FLAG_GTES = 3;
  localparam int unsigned FLAG_LTS  = 4;

  typedef enum logic [CTRL_W-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_ctrl_e;

  function automatic logic alu_ctrl_legal(input logic [CTRL_W-1:0] ctrl);
    return (ctrl <= 4'd8) || (ctrl == 4'd13);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational RV32 alu; illegal control codes produce a zero result.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic [DATA_W-1:0] res_o,
  output logic [FLAG_W-1:0] flags_o
);

  localparam int unsigned SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] shamt;
  logic            lts;
  logic            ltu;

  assign shamt = b_i[SH_W-1:0];
  assign lts   = $signed(a_i) < $signed(b_i);
  assign ltu   = a_i < b_i;

  always_comb begin
    res_o = '0;
    case (ctrl_i)
      ALU_ADD:  res_o = a_i + b_i;
      ALU_SLL:  res_o = a_i << shamt;
      ALU_SLT:  res_o = DATA_W'(lts);
      ALU_SLTU: res_o = DATA_W'(ltu);
      ALU_XOR:  res_o = a_i ^ b_i;
      ALU_SRL:  res_o = a_i >> shamt;
      ALU_OR:   res_o = a_i | b_i;
      ALU_AND:  res_o = a_i & b_i;
      ALU_SUB:  res_o = a_i - b_i;
      ALU_SRA:  res_o = DATA_W'($signed(a_i) >>> shamt);
      default:  res_o = '0;
    endcase
  end

  always_comb begin
    flags_o            = '0;
    flags_o[FLAG_LTS]  = lts;
    flags_o[FLAG_GTES] = ~lts;
    flags_o[FLAG_LTU]  = ltu;
    flags_o[FLAG_GTEU] = ~ltu;
    flags_o[FLAG_EQ]   = (res_o == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one alu between two requesters with a single registered result slot.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk_w_i,
  input  logic              rst_w_i_l,
  input  logic              req0_valid_w_i,
  output logic              req0_ready_w_o,
  input  logic [DATA_W-1:0] req0_a_w_i,
  input  logic [DATA_W-1:0] req0_b_w_i,
  input  logic [CTRL_W-1:0] req0_ctrl_w_i,
  input  logic [TAG_W-1:0]  req0_tag_w_i,
  input  logic              req1_valid_w_i,
  output logic              req1_ready_w_o,
  input  logic [DATA_W-1:0] req1_a_w_i,
  input  logic [DATA_W-1:0] req1_b_w_i,
  input  logic [CTRL_W-1:0] req1_ctrl_w_i,
  input  logic [TAG_W-1:0]  req1_tag_w_i,
  output logic              resp0_valid_w_o,
  input  logic              resp0_ready_w_i,
  output logic              resp1_valid_w_o,
  input  logic              resp1_ready_w_i,
  output logic [DATA_W-1:0] resp_res_w_o,
  output logic [FLAG_W-1:0] resp_flags_w_o,
  output logic [TAG_W-1:0]  resp_tag_w_o,
  output logic              resp_err_w_o
);

  logic              slot_valid_q, slot_valid_d;
  logic              owner_q, owner_d;
  logic              rr_q, rr_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              err_q, err_d;

  logic              owner_ready;
  logic              slot_free;
  logic              grant0, grant1;
  logic [DATA_W-1:0] mux_a, mux_b;
  logic [CTRL_W-1:0] mux_ctrl;
  logic [TAG_W-1:0]  mux_tag;
  logic [DATA_W-1:0] alu_res;
  logic [FLAG_W-1:0] alu_flags;

  // Grant logic: gated by reset so nothing is accepted while the block is held in reset.
  always_comb begin
    owner_ready = owner_q ? resp1_ready_w_i : resp0_ready_w_i;
    slot_free   = ~slot_valid_q | owner_ready;
    grant0      = 1'b0;
    grant1      = 1'b0;
    if (rst_w_i_l && slot_free) begin
      if (req0_valid_w_i && req1_valid_w_i) begin
        grant0 = ~rr_q;
        grant1 = rr_q;
      end else begin
        grant0 = req0_valid_w_i;
        grant1 = req1_valid_w_i;
      end
    end
  end

  assign req0_ready_w_o = grant0;
  assign req1_ready_w_o = grant1;

  assign mux_a    = grant1 ? req1_a_w_i    : req0_a_w_i;
  assign mux_b    = grant1 ? req1_b_w_i    : req0_b_w_i;
  assign mux_ctrl = grant1 ? req1_ctrl_w_i : req0_ctrl_w_i;
  assign mux_tag  = grant1 ? req1_tag_w_i  : req0_tag_w_i;

  alu #(.DATA_W(DATA_W)) u_alu (
    .a_i     (mux_a),
    .b_i     (mux_b),
    .ctrl_i  (mux_ctrl),
    .res_o   (alu_res),
    .flags_o (alu_flags)
  );

  // Slot update: a grant reloads the slot, otherwise an owner drain empties it.
  always_comb begin
    slot_valid_d = slot_valid_q;
    owner_d      = owner_q;
    rr_d         = rr_q;
    res_d        = res_q;
    flags_d      = flags_q;
    tag_d        = tag_q;
    err_d        = err_q;
    if (grant0 || grant1) begin
      slot_valid_d = 1'b1;
      owner_d      = grant1;
      rr_d         = grant0;
      res_d        = alu_res;
      flags_d      = alu_flags;
      tag_d        = mux_tag;
      err_d        = ~alu_ctrl_legal(mux_ctrl);
    end else if (slot_valid_q && owner_ready) begin
      slot_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
    if (!rst_w_i_l) begin
      slot_valid_q <= 1'b0;
      owner_q      <= 1'b0;
      rr_q         <= 1'b0;
      res_q        <= '0;
      flags_q      <= '0;
      tag_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      slot_valid_q <= slot_valid_d;
      owner_q      <= owner_d;
      rr_q         <= rr_d;
      res_q        <= res_d;
      flags_q      <= flags_d;
      tag_q        <= tag_d;
      err_q        <= err_d;
    end
  end

  assign resp0_valid_w_o = slot_valid_q & ~owner_q;
  assign resp1_valid_w_o = slot_valid_q & owner_q;
  assign resp_res_w_o    = res_q;
  assign resp_flags_w_o  = flags_q;
  assign resp_tag_w_o    = tag_q;
  assign resp_err_w_o    = err_q;

endmodule
